// File: rtl/desc_mem_slv_if.sv
// Wishbone bus between the DMA control master and the descriptor memory slave.
interface desc_mem_slv_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic        wbs_cab_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat64_i;
    logic [31:0] wbs_dat_o;
    logic [31:0] wbs_dat64_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_rty_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i, wbs_sel_i,
               wbs_adr_i, wbs_dat_i, wbs_dat64_i,
        input  wbs_dat_o, wbs_dat64_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i, wbs_sel_i,
               wbs_adr_i, wbs_dat_i, wbs_dat64_i,
        output wbs_dat_o, wbs_dat64_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );
endinterface

// File: rtl/desc_mem_slv.sv
// Wishbone slave backing a 64-bit descriptor memory, with a host load/inspect port.
// Responses are decoded from the current cycle's cyc/stb/host_we so that a host
// collision or a master abort in the response cycle is seen immediately.
module desc_mem_slv #(
    parameter int unsigned AW   = 6,
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int unsigned WAIT = 0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    desc_mem_slv_if.slave     wbs,
    input  logic              host_we,
    input  logic [AW-1:0]     host_adr,
    input  logic [63:0]       host_dat,
    output logic [63:0]       host_q
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = 4;
    localparam logic [CW-1:0] WAIT_C = CW'(WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  idx, idx_nxt;
    logic           hit_q, hit_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [63:0]    rd_q;
    logic [63:0]    mem [DEPTH];

    logic           req;
    logic           adr_hit;
    logic           ack_c, err_c, rty_c;
    logic           unused_adr;

    assign req        = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign adr_hit    = (wbs.wbs_adr_i[31:AW+3] == BASE[31:AW+3]);
    assign unused_adr = ^wbs.wbs_adr_i[2:0];

    // State register with burst index, hit flag and wait counter
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            idx   <= '0;
            hit_q <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            hit_q <= hit_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: latch at burst start, count waits, advance on CAB acks
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        hit_nxt   = hit_q;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    idx_nxt   = wbs.wbs_adr_i[AW+2:3];
                    hit_nxt   = adr_hit;
                    cnt_nxt   = WAIT_C;
                    state_nxt = (WAIT_C != '0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (ack_c && wbs.wbs_cab_i) begin
                    idx_nxt   = idx + AW'(1);
                    cnt_nxt   = WAIT_C;
                    state_nxt = (WAIT_C != '0) ? S_WAIT : S_RESP;
                end else begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Response decode: exactly one of ack/err/rty in a live response cycle
    always_comb begin
        ack_c = 1'b0;
        err_c = 1'b0;
        rty_c = 1'b0;
        if ((state == S_RESP) && req && !wb_rst_i) begin
            if (!hit_q) begin
                err_c = 1'b1;
            end else if (host_we) begin
                rty_c = 1'b1;
            end else begin
                ack_c = 1'b1;
            end
        end
    end

    assign wbs.wbs_ack_o   = ack_c;
    assign wbs.wbs_err_o   = err_c;
    assign wbs.wbs_rty_o   = rty_c;
    assign wbs.wbs_dat_o   = rd_q[31:0];
    assign wbs.wbs_dat64_o = rd_q[63:32];

    // Memory array: host writes win; WB writes commit at the ack edge with byte merge
    always_ff @(posedge wb_clk_i) begin
        if (host_we) begin
            mem[host_adr] <= host_dat;
        end else if (ack_c && wbs.wbs_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs.wbs_sel_i[b]) begin
                    mem[idx][8*b +: 8]      <= wbs.wbs_dat_i[8*b +: 8];
                    mem[idx][32+8*b +: 8]   <= wbs.wbs_dat64_i[8*b +: 8];
                end
            end
        end
    end

    // Read registers: WB data fetched on entry to a response cycle, host data every cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_q   <= '0;
            host_q <= '0;
        end else begin
            host_q <= mem[host_adr];
            if (state_nxt == S_RESP) begin
                rd_q <= mem[idx_nxt];
            end
        end
    end
endmodule

// File: tb/tb_desc_mem_slv.sv
// Bench for desc_mem_slv: a WAIT=0 and a WAIT=2 instance share stimulus, only the
// selected one sees cyc; a word-array model tracks each instance's memory.
module tb_desc_mem_slv;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        use2;
    logic        cyc, stb, we, cab;
    logic [3:0]  sel;
    logic [31:0] adr, dat, dat64;
    logic        host_we;
    logic [5:0]  host_adr;
    logic [63:0] host_dat;
    logic [63:0] hq0, hq2, hq;
    logic        ack, err, rty;
    logic [31:0] rdat, rdat64;

    logic [63:0] mdl [2][64];
    int          checks = 0;
    int          errors = 0;

    desc_mem_slv_if bus0();
    desc_mem_slv_if bus2();

    assign bus0.wbs_cyc_i   = cyc & ~use2;
    assign bus2.wbs_cyc_i   = cyc & use2;
    assign bus0.wbs_stb_i   = stb;
    assign bus2.wbs_stb_i   = stb;
    assign bus0.wbs_we_i    = we;
    assign bus2.wbs_we_i    = we;
    assign bus0.wbs_cab_i   = cab;
    assign bus2.wbs_cab_i   = cab;
    assign bus0.wbs_sel_i   = sel;
    assign bus2.wbs_sel_i   = sel;
    assign bus0.wbs_adr_i   = adr;
    assign bus2.wbs_adr_i   = adr;
    assign bus0.wbs_dat_i   = dat;
    assign bus2.wbs_dat_i   = dat;
    assign bus0.wbs_dat64_i = dat64;
    assign bus2.wbs_dat64_i = dat64;

    assign ack    = use2 ? bus2.wbs_ack_o   : bus0.wbs_ack_o;
    assign err    = use2 ? bus2.wbs_err_o   : bus0.wbs_err_o;
    assign rty    = use2 ? bus2.wbs_rty_o   : bus0.wbs_rty_o;
    assign rdat   = use2 ? bus2.wbs_dat_o   : bus0.wbs_dat_o;
    assign rdat64 = use2 ? bus2.wbs_dat64_o : bus0.wbs_dat64_o;
    assign hq     = use2 ? hq2 : hq0;

    desc_mem_slv #(.AW(6), .BASE(BASE), .WAIT(0)) u_dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus0.slave),
        .host_we  (host_we),
        .host_adr (host_adr),
        .host_dat (host_dat),
        .host_q   (hq0)
    );

    desc_mem_slv #(.AW(6), .BASE(BASE), .WAIT(2)) u_dut2 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus2.slave),
        .host_we  (host_we),
        .host_adr (host_adr),
        .host_dat (host_dat),
        .host_q   (hq2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte n of the 4-bit select enables byte n of both 32-bit lanes
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [3:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (s[b % 4]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic host_wr(input int a, input logic [63:0] v);
        step();
        host_we  = 1'b1;
        host_adr = 6'(a);
        host_dat = v;
        mdl[0][a] = v;
        mdl[1][a] = v;
        step();
        host_we = 1'b0;
    endtask

    task automatic host_chk(input int a, input string tag);
        step();
        host_we  = 1'b0;
        host_adr = 6'(a);
        step();
        chk(tag, hq, mdl[use2 ? 1 : 0][a]);
    endtask

    // One WB transaction of n beats; hp pulses host_we in the first response cycle
    task automatic wb_xfer(input logic w, input logic [31:0] a, input int n, input logic [3:0] s,
                           input logic hp, input logic [2:0] exp_r, input string tag);
        int beat, cyc_n, last, wt, i, di;
        logic acked;
        logic [63:0] wd, hd;
        beat = 0; cyc_n = 0; last = 0; acked = 1'b0;
        wt = use2 ? 2 : 0;
        di = use2 ? 1 : 0;
        wd = {$urandom, $urandom};
        hd = {$urandom, $urandom};
        step();
        cyc = 1'b1; stb = 1'b1; we = w; cab = (n > 1); sel = s; adr = a;
        {dat64, dat} = wd;
        while (beat < n && cyc_n < 64) begin
            step();
            cyc_n++;
            host_we = hp && (cyc_n == 1);
            if (host_we) begin
                host_adr = 6'(a >> 3);
                host_dat = hd;
            end
            if (beat == n - 1) cab = 1'b0;
            if (acked) begin
                wd = {$urandom, $urandom};
                {dat64, dat} = wd;
            end
            acked = 1'b0;
            @(negedge clk);
            if (ack || err || rty) begin
                i = (int'(a >> 3) + beat) % 64;
                chk({tag, "_resp"}, 64'({ack, err, rty}), 64'(exp_r));
                chk({tag, "_lat"}, 64'(cyc_n - last), 64'(wt + 1));
                last = cyc_n;
                if (rty) begin
                    mdl[0][i] = hd;
                    mdl[1][i] = hd;
                end else if (ack && w) begin
                    mdl[di][i] = merge(mdl[di][i], wd, s);
                end else if (ack) begin
                    chk({tag, "_rdata"}, {rdat64, rdat}, mdl[di][i]);
                end
                acked = ack;
                beat  = ack ? beat + 1 : n;
            end
        end
        if (beat < n) chk({tag, "_timeout"}, 64'(beat), 64'(n));
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cab = 1'b0; host_we = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          wi, nb;
        rst = 1'b1; use2 = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cab = 1'b0; sel = 4'h0;
        adr = '0; dat = '0; dat64 = '0;
        host_we = 1'b0; host_adr = '0; host_dat = '0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_resp", 64'({ack, err, rty}), 64'(0));
        chk("reset_rdata", {rdat64, rdat}, 64'(0));
        chk("reset_hostq", hq, 64'(0));
        step();
        rst = 1'b0;

        for (int k = 0; k < 64; k++) host_wr(k, {$urandom, $urandom});

        // WAIT=0 directed cases
        wb_xfer(1'b0, BASE + 32'h20, 4, 4'hf, 1'b0, 3'b100, "cab_rd");
        wb_xfer(1'b1, BASE + 32'h40, 4, 4'hf, 1'b0, 3'b100, "cab_wr_full");
        for (int k = 8; k < 12; k++) host_chk(k, "cab_wr_full_host");
        wb_xfer(1'b1, BASE + 32'h40, 4, 4'h1, 1'b0, 3'b100, "cab_wr_b0");
        for (int k = 8; k < 12; k++) host_chk(k, "cab_wr_b0_host");

        wb_xfer(1'b0, BASE + 32'h200, 1, 4'hf, 1'b0, 3'b010, "miss_rd");
        wb_xfer(1'b1, BASE + 32'h200, 1, 4'hf, 1'b0, 3'b010, "miss_wr");
        host_chk(0, "miss_unchanged");
        wb_xfer(1'b0, BASE + 32'h8, 1, 4'hf, 1'b0, 3'b100, "after_miss_rd");

        wb_xfer(1'b1, BASE + 32'h18, 1, 4'hf, 1'b1, 3'b001, "host_coll");
        host_chk(3, "host_coll_word");
        wb_xfer(1'b1, BASE + 32'h18, 1, 4'hf, 1'b0, 3'b100, "retry_wr");
        host_chk(3, "retry_word");

        wb_xfer(1'b1, BASE + 32'(62 * 8), 4, 4'hf, 1'b0, 3'b100, "wrap_wr");
        wb_xfer(1'b0, BASE + 32'(62 * 8), 4, 4'hf, 1'b0, 3'b100, "wrap_rd");

        // Randomized in-range traffic, including ignored low address bits
        for (int k = 0; k < 12; k++) begin
            wi = int'($urandom_range(0, 63));
            nb = ($urandom_range(0, 1) == 0) ? 1 : 4;
            a  = BASE + 32'(wi * 8) + 32'($urandom_range(0, 7));
            wb_xfer(1'($urandom_range(0, 1)), a, nb, 4'($urandom_range(0, 15)), 1'b0,
                    3'b100, "rand");
        end
        a = BASE ^ (32'h1 << $urandom_range(9, 31));
        wb_xfer(1'b0, a, 1, 4'hf, 1'b0, 3'b010, "rand_miss");
        for (int k = 0; k < 6; k++) host_chk(int'($urandom_range(0, 63)), "rand_host");

        // Reset during beat 2 of a CAB read
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cab = 1'b1; sel = 4'hf; adr = BASE + 32'h80;
        step();
        @(negedge clk);
        chk("rst_beat1_ack", 64'(ack), 64'(1));
        chk("rst_beat1_data", {rdat64, rdat}, mdl[0][16]);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_resp", 64'({ack, err, rty}), 64'(0));
        step();
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; cab = 1'b0;
        @(negedge clk);
        chk("rst_after_resp", 64'({ack, err, rty}), 64'(0));
        chk("rst_after_rdata", {rdat64, rdat}, 64'(0));
        chk("rst_after_hostq", hq, 64'(0));
        wb_xfer(1'b0, BASE + 32'h88, 1, 4'hf, 1'b0, 3'b100, "post_rst_rd");

        // WAIT=2 instance
        use2 = 1'b1;
        wb_xfer(1'b0, BASE + 32'(int'($urandom_range(0, 63)) * 8), 1, 4'hf, 1'b0, 3'b100, "w2_single");
        wb_xfer(1'b0, BASE + 32'h20, 4, 4'hf, 1'b0, 3'b100, "w2_cab_rd");
        wb_xfer(1'b1, BASE + 32'h100, 4, 4'($urandom_range(1, 15)), 1'b0, 3'b100, "w2_cab_wr");
        for (int k = 32; k < 36; k++) host_chk(k, "w2_host");
        wb_xfer(1'b0, BASE + 32'h200, 1, 4'hf, 1'b0, 3'b010, "w2_miss");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
